// File: rtl/combine_pkg.sv
// ---------------------------------------------------------------------------
// combine_pkg
// Shared types and constants for the slave-side arbitration and join logic.
//   arb_state_t : packet arbiter state encoding (IDLE, BUSY)
//   BEAT_CNT_W  : width of the per-packet beat counter
// ---------------------------------------------------------------------------
package combine_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01
    } arb_state_t;

    localparam int BEAT_CNT_W = 16;

endpackage : combine_pkg

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Finds the first set bit of i_req,
// searching upward from (i_last + 1) mod N with wrap-around.
// Ports:
//   i_req   [N]     request vector
//   i_last  [ID_W]  index of the previous winner
//   o_found         at least one request is set
//   o_idx   [ID_W]  winning index (0 when o_found = 0)
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_last,
    output logic            o_found,
    output logic [ID_W-1:0] o_idx
);

    logic [N-1:0] w_rot;
    int           w_start;
    int           w_ofs;

    // Rotate so the highest-priority requester sits at bit 0, take the lowest
    // set bit, then map the offset back to a master index.
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_start = (int'(i_last) + 1) % N;
        w_rot   = '0;
        for (int i = 0; i < N; i++) begin
            w_rot[i] = i_req[(w_start + i) % N];
        end
        w_ofs = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_ofs = i;
            end
        end
        o_found = |w_rot;
        o_idx   = o_found ? ID_W'((w_start + w_ofs) % N) : '0;
    end

endmodule : rr_pick

// File: rtl/packet_rr_arbiter.sv
// ---------------------------------------------------------------------------
// packet_rr_arbiter
// Shares one downstream slave port between N masters, round-robin at packet
// granularity. The grant is chosen in an IDLE cycle (one bubble per packet)
// and then held from the first beat through the end beat.
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_master_valid [N]   per-master beat valid
//   o_master_ready [N]   per-master beat accept (only the granted master)
//   i_master_end   [N]   per-master last-beat flag
//   i_master_data  [N*DATA_W] payloads, master k at [k*DATA_W +: DATA_W]
//   i_master_enable[N]   mask for new grants only
//   o_slave_valid/o_slave_end/o_slave_data, i_slave_ready : slave port
//   o_grant_id [ID_W]    granted master index (meaningful while o_busy)
//   o_busy               packet in flight
// ---------------------------------------------------------------------------
module packet_rr_arbiter
    import combine_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [N-1:0]          i_master_valid,
    output logic [N-1:0]          o_master_ready,
    input  logic [N-1:0]          i_master_end,
    input  logic [N*DATA_W-1:0]   i_master_data,
    input  logic [N-1:0]          i_master_enable,
    output logic                  o_slave_valid,
    input  logic                  i_slave_ready,
    output logic                  o_slave_end,
    output logic [DATA_W-1:0]     o_slave_data,
    output logic [$clog2(N)-1:0]  o_grant_id,
    output logic                  o_busy
);

    localparam int ID_W = $clog2(N);

    arb_state_t            r_state;
    logic [ID_W-1:0]       r_grant;
    logic [ID_W-1:0]       r_last;
    logic [BEAT_CNT_W-1:0] r_beat_cnt;

    logic                  w_busy;
    logic                  w_found;
    logic [ID_W-1:0]       w_idx;
    logic                  w_xfer;

    // Enable masks only new grants; a packet already granted ignores it.
    rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .i_req   (i_master_valid & i_master_enable),
        .i_last  (r_last),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    assign w_busy = (r_state == BUSY);

    // Combinational steering of the granted master onto the slave port.
    // In IDLE everything is forced to 0 so no stale payload leaks out.
    always_comb begin
        o_master_ready = '0;
        o_slave_valid  = 1'b0;
        o_slave_end    = 1'b0;
        o_slave_data   = '0;
        if (w_busy) begin
            o_slave_valid           = i_master_valid[r_grant];
            o_slave_end             = i_master_end[r_grant];
            o_slave_data            = i_master_data[r_grant*DATA_W +: DATA_W];
            o_master_ready[r_grant] = i_slave_ready;
        end
    end

    assign w_xfer     = o_slave_valid & i_slave_ready;
    assign o_busy     = w_busy;
    assign o_grant_id = r_grant;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            // r_last = N-1 makes master 0 the first in line after reset.
            r_last     <= ID_W'(N - 1);
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant <= w_idx;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_xfer) begin
                        if (o_slave_end) begin
                            // Regrant waits for the next IDLE cycle, which
                            // then sees the updated r_last.
                            r_last     <= r_grant;
                            r_state    <= IDLE;
                            r_beat_cnt <= '0;
                        end else if (r_beat_cnt != '1) begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : packet_rr_arbiter

// File: tb/tb_packet_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_packet_rr_arbiter
// Randomized and directed stimulus against a packet-level reference model.
// ---------------------------------------------------------------------------
module tb_packet_rr_arbiter;

    localparam int N      = 4;
    localparam int DATA_W = 32;
    localparam int ID_W   = $clog2(N);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N-1:0]        m_valid = '0;
    logic [N-1:0]        m_ready;
    logic [N-1:0]        m_end = '0;
    logic [N*DATA_W-1:0] m_data = '0;
    logic [N-1:0]        m_enable = '1;
    logic                s_valid;
    logic                s_ready = 1'b0;
    logic                s_end;
    logic [DATA_W-1:0]   s_data;
    logic [ID_W-1:0]     grant_id;
    logic                busy;

    always #5 clk = ~clk;

    packet_rr_arbiter #(.N(N), .DATA_W(DATA_W)) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_master_valid  (m_valid),
        .o_master_ready  (m_ready),
        .i_master_end    (m_end),
        .i_master_data   (m_data),
        .i_master_enable (m_enable),
        .o_slave_valid   (s_valid),
        .i_slave_ready   (s_ready),
        .o_slave_end     (s_end),
        .o_slave_data    (s_data),
        .o_grant_id      (grant_id),
        .o_busy          (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Master drivers: remaining beats per master, valid hold-off, beat sequence.
    int pk_len[N];
    bit hold[N];
    int seq[N];
    bit refill;

    // Reference model: packet-level view of who owns the slave port.
    bit m_busy;
    int m_gid;
    int m_last;
    int m_cnt;
    bit chk_en;

    // Grants observed on the DUT, in order, for the directed scenarios.
    int gq[$];
    int exp_q[$];
    bit prev_busy;

    task automatic drive();
        logic [DATA_W-1:0] d;
        for (int k = 0; k < N; k++) begin
            m_valid[k] = (pk_len[k] > 0) && !hold[k];
            m_end[k]   = (pk_len[k] == 1);
            d = DATA_W'((k << 24) | (seq[k] & 32'h00FF_FFFF));
            m_data[k*DATA_W +: DATA_W] = d;
        end
    endtask

    task automatic cycle();
        logic [N-1:0]      e_ready;
        logic              e_valid;
        logic              e_end;
        logic [DATA_W-1:0] e_data;
        logic [N-1:0]      req;
        bit                found;
        int                c;
        drive();
        @(negedge clk);
        e_ready = '0;
        e_valid = 1'b0;
        e_end   = 1'b0;
        e_data  = '0;
        if (m_busy) begin
            e_valid        = m_valid[m_gid];
            e_end          = m_end[m_gid];
            e_data         = m_data[m_gid*DATA_W +: DATA_W];
            e_ready[m_gid] = s_ready;
        end
        if (chk_en) begin
            check("busy",        busy,              m_busy);
            check("grant_id",    grant_id,          m_gid);
            check("slave_valid", s_valid,           e_valid);
            check("slave_end",   s_end,             e_end);
            check("slave_data",  s_data,            e_data);
            check("master_rdy",  m_ready,           e_ready);
            check("beat_cnt",    dut.r_beat_cnt,    m_cnt);
        end
        if (busy && !prev_busy) gq.push_back(int'(grant_id));
        prev_busy = busy;

        // Model next state.
        if (rst) begin
            m_busy = 0; m_gid = 0; m_last = N - 1; m_cnt = 0;
            prev_busy = 0;
        end else if (!m_busy) begin
            req   = m_valid & m_enable;
            found = 0;
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!found && req[c]) begin
                    found = 1; m_gid = c; m_busy = 1;
                end
            end
        end else if (e_valid && s_ready) begin
            if (e_end) begin
                m_last = m_gid; m_busy = 0; m_cnt = 0;
            end else if (m_cnt < 65535) begin
                m_cnt++;
            end
        end

        // Drivers advance on accepted beats.
        for (int k = 0; k < N; k++) begin
            if (!rst && e_ready[k] && m_valid[k]) begin
                pk_len[k]--; seq[k]++;
            end
            if (refill && pk_len[k] == 0) pk_len[k] = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_drivers();
        for (int k = 0; k < N; k++) begin
            pk_len[k] = 0; hold[k] = 0;
        end
        refill = 0;
    endtask

    task automatic do_reset();
        clear_drivers();
        rst = 1; s_ready = 0; m_enable = '1;
        cycle();
        rst = 0;
        gq.delete();
    endtask

    task automatic check_order(input string tag);
        check({tag, "_len"}, gq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < gq.size()) check(tag, gq[i], exp_q[i]);
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) seq[k] = 0;
        m_busy = 0; m_gid = 0; m_last = N - 1; m_cnt = 0;
        prev_busy = 0; chk_en = 0;
        do_reset();
        chk_en = 1;
        check("rst_busy",  busy,     0);
        check("rst_valid", s_valid,  0);
        check("rst_ready", m_ready,  0);
        check("rst_data",  s_data,   0);
        check("rst_gid",   grant_id, 0);

        // Masters 0 and 2, 3-beat packets, slave always ready.
        pk_len[0] = 3; pk_len[2] = 3; s_ready = 1;
        for (int i = 0; i < 12; i++) cycle();
        exp_q = '{0, 2};
        check_order("s1_order");

        // All masters, single-beat packets back-to-back.
        do_reset();
        refill = 1; s_ready = 1;
        for (int k = 0; k < N; k++) pk_len[k] = 1;
        for (int i = 0; i < 10; i++) cycle();
        exp_q = '{0, 1, 2, 3, 0};
        check_order("s2_order");

        // Master 1 drops valid mid-packet while master 3 waits.
        do_reset();
        pk_len[1] = 4; pk_len[3] = 2; s_ready = 1;
        for (int i = 0; i < 14; i++) begin
            hold[1] = (i >= 3 && i < 6);
            cycle();
        end
        exp_q = '{1, 3};
        check_order("s3_order");

        // Slave stalls for 5 cycles on master 0's second beat.
        do_reset();
        pk_len[0] = 3;
        for (int i = 0; i < 12; i++) begin
            s_ready = !(i >= 2 && i < 7);
            cycle();
        end
        exp_q = '{0};
        check_order("s4_order");

        // Enable mask with r_last = 1: master 3 wins, master 2 is skipped.
        do_reset();
        pk_len[1] = 1; s_ready = 1;
        for (int i = 0; i < 3; i++) cycle();
        m_enable = 4'b1011;
        pk_len[2] = 2; pk_len[3] = 2;
        for (int i = 0; i < 10; i++) cycle();
        exp_q = '{1, 3};
        check_order("s5_masked");
        m_enable = 4'b1111;
        for (int i = 0; i < 5; i++) cycle();
        exp_q = '{1, 3, 2};
        check_order("s5_unmasked");

        // Reset in the middle of master 2's packet.
        do_reset();
        pk_len[2] = 4; s_ready = 1;
        for (int i = 0; i < 3; i++) cycle();
        rst = 1; s_ready = 0;
        cycle();
        rst = 0;
        gq.delete();
        check("mid_rst_busy",  busy,     0);
        check("mid_rst_valid", s_valid,  0);
        check("mid_rst_end",   s_end,    0);
        check("mid_rst_ready", m_ready,  0);
        check("mid_rst_data",  s_data,   0);
        check("mid_rst_gid",   grant_id, 0);
        pk_len[0] = 2; s_ready = 1;
        for (int i = 0; i < 10; i++) cycle();
        exp_q = '{0, 2};
        check_order("s6_order");

        // Random traffic, enables, stalls, hold-offs and occasional resets.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < N; k++) begin
                if (pk_len[k] == 0 && ($urandom % 4) == 0) pk_len[k] = 1 + int'($urandom % 4);
                hold[k]     = (($urandom % 5) == 0);
                m_enable[k] = (($urandom % 4) != 0);
            end
            s_ready = (($urandom % 3) != 0);
            rst     = (($urandom % 80) == 0);
            if (rst) s_ready = 0;
            cycle();
        end
        rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_packet_rr_arbiter
